// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write arbiter and the FIFObuffer write port.
// The slave modport is the arbiter's view; master is the producer/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 4,
  parameter int unsigned IDW  = 2
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               fifo_rd;
  logic               FULL;
  logic               EN;
  logic               WR;
  logic [DW-1:0]      dataIn;
  logic [IDW-1:0]     grant_id;
  logic [CNTW-1:0]    level;

  modport slave (
    input  req_valid, req_data, fifo_rd, FULL,
    output req_ready, EN, WR, dataIn, grant_id, level
  );

  modport master (
    output req_valid, req_data, fifo_rd, FULL,
    input  req_ready, EN, WR, dataIn, grant_id, level
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFObuffer write port among NREQ valid/ready producers,
// with a local credit counter that mirrors FIFO occupancy so no write lands in a full FIFO.
module fifo_wr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNTW  = 4,
  parameter int unsigned IDW   = 2
) (
  input logic              Clk,
  input logic              Rst,
  fifo_wr_arbiter_if.slave bus
);

  logic [IDW-1:0]  last_q;
  logic [IDW-1:0]  gnt;
  logic [IDW-1:0]  idx;
  logic            found;
  logic            can_acc;
  logic            accept;
  logic            rd_eff;
  logic [NREQ-1:0] ready;
  logic [DW-1:0]   win_data;

  logic            en_q;
  logic            wr_q;
  logic [DW-1:0]   data_q;
  logic [IDW-1:0]  gid_q;
  logic [CNTW-1:0] level_q;
  logic [CNTW-1:0] level_d;

  assign can_acc = !Rst && !bus.FULL && (level_q < CNTW'(DEPTH));

  // Scan starts one past the last winner so every requester gets a turn.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= NREQ; i++) begin
      idx = IDW'((32'(last_q) + i) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
  end

  always_comb begin
    ready = '0;
    if (found) begin
      ready[gnt] = can_acc;
    end
  end

  always_comb begin
    win_data = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (IDW'(i) == gnt) begin
        win_data = bus.req_data[i*DW +: DW];
      end
    end
  end

  assign accept = |(bus.req_valid & ready);
  assign rd_eff = bus.fifo_rd && (level_q != '0);

  // Accept is already gated by level < DEPTH, so the counter cannot overflow.
  always_comb begin
    level_d = level_q;
    if (accept && !rd_eff) begin
      level_d = level_q + CNTW'(1);
    end else if (!accept && rd_eff) begin
      level_d = level_q - CNTW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      level_q <= '0;
    end else begin
      en_q    <= 1'b1;
      wr_q    <= accept;
      level_q <= level_d;
      if (accept) begin
        data_q <= win_data;
        gid_q  <= gnt;
        last_q <= gnt;
      end
    end
  end

  assign bus.req_ready = ready;
  assign bus.EN        = en_q;
  assign bus.WR        = wr_q;
  assign bus.dataIn    = data_q;
  assign bus.grant_id  = gid_q;
  assign bus.level     = level_q;

endmodule
